instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Phase sequencer and instruction register for the multicycle MIPS core. Issues the instruction read on the Avalon bus, byte-swaps and latches the returned word, and drives the one-hot `fetch` / `exec_one` / `exec_two` phase strobes together with `current_instruction`, which the decode stage consumes directly. Also owns the `active` flag, the halt transition, and a retired-instruction counter.

## Interface

Parameters:
- `CNT_W`, default 32: width of `instr_count`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `pc`, in, 32: address of the next instruction; owned by the PC block.
- `instr_address`, out, 32: Avalon instruction address; equals `pc` while `instr_read` is high.
- `instr_read`, out, 1: Avalon read request.
- `instr_readdata`, in, 32: Avalon read data, little-endian byte order.
- `waitrequest`, in, 1: Avalon wait; the read is held while this is high.
- `mem_stall`, in, 1: data-memory busy; freezes the EXEC1 or EXEC2 phase.
- `halt_req`, in, 1: PC block reports a jump to address 0; sampled at EXEC2 exit.
- `fetch`, out, 1: FETCH phase strobe.
- `exec_one`, out, 1: EXEC1 phase strobe.
- `exec_two`, out, 1: EXEC2 phase strobe.
- `current_instruction`, out, 32: latched instruction, big-endian (MIPS) order.
- `active`, out, 1: CPU running.
- `instr_count`, out, CNT_W: number of instructions retired.

## Operation

States: INIT, FETCH, EXEC1, EXEC2, HALTED.

- **INIT**: entered on reset. All strobes 0, `instr_read` = 0, `active` = 1. Moves to FETCH unconditionally on the next edge.
- **FETCH**: `fetch` = 1, `instr_read` = 1, `instr_address` = `pc`.
  - `waitrequest` = 1: stay in FETCH; read and address held stable.
  - `waitrequest` = 0: latch `current_instruction` = {rd[7:0], rd[15:8], rd[23:16], rd[31:24]} and go to EXEC1.
- **EXEC1**: `exec_one` = 1. If `mem_stall` = 1, stay. Otherwise go to EXEC2.
- **EXEC2**: `exec_two` = 1.
  - If `mem_stall` = 1, stay.
  - Otherwise increment `instr_count` (wraps at 2^CNT_W − 1 → 0). Then go to HALTED if `halt_req` = 1, else to FETCH.
- **HALTED**: all strobes 0, `instr_read` = 0, `active` = 0. The block stays here until `rst_n` is asserted.

Invariants:
- Strobes are strictly one-hot or all-zero; they are registered state decodes, never glitching combinational paths.
- `current_instruction` changes only on a FETCH completion edge, so it is stable throughout EXEC1 and EXEC2.
- `instr_readdata` is ignored outside FETCH.
- `waitrequest` is ignored outside FETCH.

## Timing

- Reset values: state = INIT, `current_instruction` = 0, `instr_count` = 0, `active` = 1, `fetch` = `exec_one` = `exec_two` = `instr_read` = 0.
- Reset mid-operation (any state, including a pending read): returns immediately to INIT. The outstanding read is abandoned by dropping `instr_read` asynchronously.
- Minimum instruction latency is 3 cycles (FETCH, EXEC1, EXEC2) with zero wait states. Each `waitrequest` cycle and each `mem_stall` cycle adds one cycle.
- `mem_stall` and `halt_req` both high in EXEC2: the stall wins, no count is taken, and `halt_req` is re-sampled when the stall clears.
- `halt_req` outside EXEC2 has no effect.
- The first FETCH read is issued in cycle 2 after reset release (INIT occupies cycle 1).

## Structure

- Shared package `mips_pkg`:
  - state enum `phase_t`;
  - constant `RESET_VECTOR` = 32'hBFC0_0000, for the PC block;
  - byte-swap function `bswap32`, reused by the data-memory path.
- One natural sub-module: `avalon_read_port`, which holds read/address until `waitrequest` falls and presents the swapped data. Optional; a single module is acceptable.

## Test plan

- Reset, zero-wait memory returning 32'h2000_0824 at `pc` = 32'hBFC0_0000 → INIT for 1 cycle; `fetch` in cycle 2; `current_instruction` = 32'h2408_0020 during EXEC1 and EXEC2; `instr_count` = 1 after EXEC2.
- `waitrequest` held high for 3 cycles in FETCH → `fetch` high for 4 cycles; `instr_read` and `instr_address` stable throughout; EXEC1 follows the release edge.
- `mem_stall` high for 2 cycles in EXEC2 with `halt_req` = 1 → `exec_two` high for 3 cycles; then HALTED with `active` = 0; `instr_count` incremented once.
- `rst_n` asserted mid-FETCH while `waitrequest` = 1 → `instr_read` drops immediately; state INIT; `instr_count` = 0; `current_instruction` = 0.
- `CNT_W` = 4, run 17 instructions → `instr_count` = 1; strobes never overlap (assertion on the one-hot/zero invariant over all cycles).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: phase encoding, boot vector
// and the little-endian to MIPS byte-order swap.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        PH_INIT   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_EXEC1  = 3'd2,
        PH_EXEC2  = 3'd3,
        PH_HALTED = 3'd4
    } phase_t;

    localparam logic [WORD_W-1:0] RESET_VECTOR = 32'hBFC0_0000;

    // Avalon returns little-endian words; MIPS decode expects big-endian.
    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/avalon_read_port.sv
// Avalon-MM read master for instruction words: holds the request until
// waitrequest falls and latches the byte-swapped word on acceptance.
module avalon_read_port
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_next_i,
    input  logic [WORD_W-1:0] readdata_i,
    input  logic              waitrequest_i,
    output logic              read_o,
    output logic [WORD_W-1:0] data_o,
    output logic              accept_c
);

    logic              read_q;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    // A read completes on any edge where it is requested and not stalled.
    assign accept_c = read_q & ~waitrequest_i;

    always_comb begin
        data_d = data_q;
        if (accept_c) begin
            data_d = bswap32(readdata_i);
        end
    end

    // Async reset drops the request immediately, abandoning any pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q <= 1'b0;
            data_q <= '0;
        end else begin
            read_q <= read_next_i;
            data_q <= data_d;
        end
    end

    assign read_o = read_q;
    assign data_o = data_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Phase sequencer and instruction register for the multicycle MIPS core:
// INIT -> FETCH -> EXEC1 -> EXEC2 -> (FETCH | HALTED), with a retired counter.
module instr_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr_address,
    output logic              instr_read,
    input  logic [WORD_W-1:0] instr_readdata,
    input  logic              waitrequest,
    input  logic              mem_stall,
    input  logic              halt_req,
    output logic              fetch,
    output logic              exec_one,
    output logic              exec_two,
    output logic [WORD_W-1:0] current_instruction,
    output logic              active,
    output logic [CNT_W-1:0]  instr_count
);

    phase_t             state_q;
    phase_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               fetch_q;
    logic               exec_one_q;
    logic               exec_two_q;
    logic               active_q;
    logic               fetch_d;
    logic               exec_one_d;
    logic               exec_two_d;
    logic               active_d;
    logic               accept_c;
    logic               read_next;

    assign read_next = (state_d == PH_FETCH);

    avalon_read_port u_read_port (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_next_i   (read_next),
        .readdata_i    (instr_readdata),
        .waitrequest_i (waitrequest),
        .read_o        (instr_read),
        .data_o        (current_instruction),
        .accept_c      (accept_c)
    );

    // The PC block holds pc steady for the whole FETCH phase.
    assign instr_address = pc;

    // Next-state, retire counter and registered phase decodes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fetch_d    = 1'b0;
        exec_one_d = 1'b0;
        exec_two_d = 1'b0;
        active_d   = 1'b1;

        case (state_q)
            PH_INIT: begin
                state_d = PH_FETCH;
            end
            PH_FETCH: begin
                if (accept_c) begin
                    state_d = PH_EXEC1;
                end
            end
            PH_EXEC1: begin
                if (!mem_stall) begin
                    state_d = PH_EXEC2;
                end
            end
            PH_EXEC2: begin
                // A stall defers both the retire and the halt decision.
                if (!mem_stall) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = halt_req ? PH_HALTED : PH_FETCH;
                end
            end
            PH_HALTED: begin
                state_d = PH_HALTED;
            end
            default: begin
                state_d = PH_INIT;
            end
        endcase

        fetch_d    = (state_d == PH_FETCH);
        exec_one_d = (state_d == PH_EXEC1);
        exec_two_d = (state_d == PH_EXEC2);
        active_d   = (state_d != PH_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PH_INIT;
            count_q    <= '0;
            fetch_q    <= 1'b0;
            exec_one_q <= 1'b0;
            exec_two_q <= 1'b0;
            active_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_q    <= fetch_d;
            exec_one_q <= exec_one_d;
            exec_two_q <= exec_two_d;
            active_q   <= active_d;
        end
    end

    assign fetch       = fetch_q;
    assign exec_one    = exec_one_q;
    assign exec_two    = exec_two_q;
    assign active      = active_q;
    assign instr_count = count_q;

endmodule
